psk_tx_scheduler: RTL and testbench

Frame-level transmit controller that sequences the PSK modulator on the 16.384 MHz domain. It takes a byte stream from the payload FIFO and emits one symbol per modulator acknowledge. Each frame is a BPSK preamble, a BPSK length header, QPSK payload and idle guard slots, with AXIS `tuser` carrying is_bpsk. It sits between the TX payload FIFO and the modulator's AXIS data input.

---
 rtl/psk_pkg.sv | 51 +++++
 rtl/psk_crc8.sv | 23 ++
 rtl/psk_tx_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_psk_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared definitions for the PSK transmit scheduler: FSM states, preamble
// start bit, CRC-8 constants and symbol field positions.
// Optional build macro: PSK_SCHED_CRC_EN adds the CRC state.
package psk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
`ifdef PSK_SCHED_CRC_EN
        ST_CRC      = 3'd4,
`endif
        ST_GUARD    = 3'd5
    } state_t;

    localparam logic       PRE_START_BIT = 1'b1;
    localparam logic [7:0] CRC_POLY      = 8'h07;
    localparam logic [7:0] CRC_INIT      = 8'h00;
    localparam int         SYM_I_BIT     = 1;
    localparam int         SYM_Q_BIT     = 0;

    // One byte of MSB-first CRC-8, no reflection.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    // BPSK: the same bit on I and Q.
    function automatic logic [7:0] bpsk_sym(input logic b);
        logic [7:0] s;
        s            = '0;
        s[SYM_I_BIT] = b;
        s[SYM_Q_BIT] = b;
        return s;
    endfunction

    // QPSK: upper bit of the pair on I, lower on Q.
    function automatic logic [7:0] qpsk_sym(input logic [1:0] p);
        logic [7:0] s;
        s            = '0;
        s[SYM_I_BIT] = p[1];
        s[SYM_Q_BIT] = p[0];
        return s;
    endfunction

endpackage

// File: rtl/psk_crc8.sv
// Byte-serial CRC-8 accumulator, one byte per cycle, with synchronous clear.
// Only instantiated when PSK_SCHED_CRC_EN is defined.
module psk_crc8
    import psk_pkg::*;
(
    input  logic       clk_16M384,
    input  logic       rst_16M384,
    input  logic       clr,
    input  logic       valid,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    // Accumulate one byte per valid cycle; clear restarts from the init value.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384 || clr) begin
            crc <= CRC_INIT;
        end else if (valid) begin
            crc <= crc8_next(crc, data);
        end
    end

endmodule

// File: rtl/psk_tx_scheduler.sv
// Frame-level transmit controller for the PSK modulator: BPSK preamble,
// BPSK length header, QPSK payload, optional CRC-8, idle guard slots.
// Optional build macro: PSK_SCHED_CRC_EN appends a 4-symbol CRC-8.
module psk_tx_scheduler
    import psk_pkg::*;
#(
    parameter int unsigned PRE_LEN   = 16,
    parameter int unsigned GUARD_LEN = 4
) (
    input  logic       clk_16M384,
    input  logic       rst_16M384,
    input  logic       en,
    input  logic [7:0] cfg_len,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       busy,
    output logic       frame_done,
    output logic       err_len
);

    localparam state_t POST_STATE = (GUARD_LEN == 0) ? ST_IDLE : ST_GUARD;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] len_q;
    logic [8:0] len_ext, byte_cnt, fetch_cnt;
    logic [1:0] pair, cur_pair;
    logic       ur;             // current payload slot is an underrun (idle) slot
    logic [7:0] cur_byte, hold_data, load_byte;
    logic       hold_full, pad;
    logic       start, load_req, load_ok, acc, fin_byte, qpsk_state;
`ifdef PSK_SCHED_CRC_EN
    logic       crc_load;
    logic [7:0] crc_val;
`endif

    assign len_ext   = {1'b0, len_q} + 9'd1;
    assign fin_byte  = (byte_cnt == len_ext);
    assign s_tready  = !hold_full && !pad && (fetch_cnt < len_ext) &&
                       (state == ST_HEADER || state == ST_PAYLOAD);
    assign acc       = s_tvalid && s_tready;
    // Held byte first, then a byte arriving this cycle, then padding zeros.
    assign load_ok   = hold_full || acc || pad;
    assign load_byte = hold_full ? hold_data : (acc ? s_tdata : 8'h00);
    assign busy      = (state != ST_IDLE);
`ifdef PSK_SCHED_CRC_EN
    assign qpsk_state = (state == ST_PAYLOAD) || (state == ST_CRC);
`else
    assign qpsk_state = (state == ST_PAYLOAD);
`endif

    // FSM state and per-state symbol counter.
    always_ff @(posedge clk_16M384) begin
        // NOTE: registers are written with <= so every flop samples pre-edge values.
        if (rst_16M384) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; each m_tready acknowledge advances one symbol slot.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        load_req  = 1'b0;
`ifdef PSK_SCHED_CRC_EN
        crc_load  = 1'b0;
`endif
        case (state)
            ST_IDLE: if (en && s_tvalid) begin
                state_nxt = ST_PREAMBLE;
                cnt_nxt   = '0;
                start     = 1'b1;
            end
            ST_PREAMBLE: if (m_tready) begin
                if (cnt == 8'(PRE_LEN - 1)) begin
                    state_nxt = ST_HEADER;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_HEADER: if (m_tready) begin
                if (cnt == 8'd7) begin
                    state_nxt = ST_PAYLOAD;
                    load_req  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_PAYLOAD: if (m_tready) begin
                if (!ur && pair == 2'd3 && fin_byte) begin
`ifdef PSK_SCHED_CRC_EN
                    state_nxt = ST_CRC;
                    crc_load  = 1'b1;
`else
                    state_nxt = POST_STATE;
                    cnt_nxt   = '0;
`endif
                end else if (ur || pair == 2'd3) begin
                    load_req = 1'b1;
                end
            end
`ifdef PSK_SCHED_CRC_EN
            ST_CRC: if (m_tready && pair == 2'd3) begin
                state_nxt = POST_STATE;
                cnt_nxt   = '0;
            end
`endif
            ST_GUARD: if (m_tready) begin
                if (cnt == 8'(GUARD_LEN - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Byte holding register, payload byte/pair tracking and status pulses.
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            // NOTE: data registers are reset too so a dropped byte never reappears.
            len_q      <= '0;
            byte_cnt   <= '0;
            fetch_cnt  <= '0;
            pair       <= '0;
            ur         <= 1'b0;
            cur_byte   <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            pad        <= 1'b0;
            frame_done <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            frame_done <= m_tready && m_tlast;
            err_len    <= acc && (s_tlast ? (fetch_cnt != {1'b0, len_q})
                                          : (fetch_cnt == {1'b0, len_q}));
            if (start) begin
                len_q     <= cfg_len;
                byte_cnt  <= '0;
                fetch_cnt <= '0;
                pad       <= 1'b0;
                hold_full <= 1'b0;
                ur        <= 1'b0;
                pair      <= '0;
            end
            if (acc) begin
                fetch_cnt <= fetch_cnt + 9'd1;
                if (s_tlast && fetch_cnt != {1'b0, len_q}) pad <= 1'b1;
            end
            // A byte arriving exactly when one is due bypasses the register.
            if (acc && !load_req) begin
                hold_data <= s_tdata;
                hold_full <= 1'b1;
            end else if (load_req && hold_full) begin
                hold_full <= 1'b0;
            end
            if (load_req) begin
                pair <= '0;
                if (load_ok) begin
                    cur_byte <= load_byte;
                    byte_cnt <= byte_cnt + 9'd1;
                    ur       <= 1'b0;
                end else begin
                    ur <= 1'b1;
                end
            end
`ifdef PSK_SCHED_CRC_EN
            else if (crc_load) begin
                cur_byte <= crc_val;
                pair     <= '0;
            end
`endif
            else if (m_tready && qpsk_state) begin
                pair <= pair + 2'd1;
            end
        end
    end

    // Select the current bit pair of the byte, MSB pair first.
    always_comb begin
        case (pair)
            2'd0:    cur_pair = cur_byte[7:6];
            2'd1:    cur_pair = cur_byte[5:4];
            2'd2:    cur_pair = cur_byte[3:2];
            default: cur_pair = cur_byte[1:0];
        endcase
    end

    // Symbol output decode from registered state.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                m_tdata  = bpsk_sym(PRE_START_BIT ^ cnt[0]);
                m_tvalid = 1'b1;
                m_tuser  = 1'b1;
            end
            ST_HEADER: begin
                m_tdata  = bpsk_sym(len_q[3'd7 - cnt[2:0]]);
                m_tvalid = 1'b1;
                m_tuser  = 1'b1;
            end
            ST_PAYLOAD: if (!ur) begin
                m_tdata  = qpsk_sym(cur_pair);
                m_tvalid = 1'b1;
`ifndef PSK_SCHED_CRC_EN
                m_tlast  = (pair == 2'd3) && fin_byte;
`endif
            end
`ifdef PSK_SCHED_CRC_EN
            ST_CRC: begin
                m_tdata  = qpsk_sym(cur_pair);
                m_tvalid = 1'b1;
                m_tlast  = (pair == 2'd3);
            end
`endif
            default: ;
        endcase
    end

`ifdef PSK_SCHED_CRC_EN
    psk_crc8 u_crc (
        .clk_16M384 (clk_16M384),
        .rst_16M384 (rst_16M384),
        .clr        (start),
        .valid      (load_req && load_ok),
        .data       (load_byte),
        .crc        (crc_val)
    );
`endif

endmodule

// File: tb/tb_psk_tx_scheduler.sv
// Directed testbench for psk_tx_scheduler (PRE_LEN=4, GUARD_LEN=2).
// Acknowledged symbols are captured and compared to hand-built sequences.
module tb_psk_tx_scheduler;

    localparam int PRE_LEN   = 4;
    localparam int GUARD_LEN = 2;
`ifdef PSK_SCHED_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk_16M384 = 1'b0;
    logic       rst_16M384 = 1'b1;
    logic       en = 1'b0;
    logic [7:0] cfg_len = '0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       m_tready = 1'b0;
    logic       s_tready, m_tvalid, m_tlast, m_tuser, busy, frame_done, err_len;
    logic [7:0] m_tdata;

    int n_checks = 0;
    int n_errors = 0;
    int tick = 0;
    int n_done = 0, n_done_bad = 0, n_err = 0, n_acc = 0;
    logic        prev_last_ack = 1'b0;
    logic [10:0] cap[$];
    logic [10:0] exp_q[$];
    logic [7:0]  exp_crc;

    psk_tx_scheduler #(.PRE_LEN(PRE_LEN), .GUARD_LEN(GUARD_LEN)) dut (
        .clk_16M384 (clk_16M384),
        .rst_16M384 (rst_16M384),
        .en         (en),
        .cfg_len    (cfg_len),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tuser    (m_tuser),
        .busy       (busy),
        .frame_done (frame_done),
        .err_len    (err_len)
    );

    initial forever #5 clk_16M384 = ~clk_16M384;

    // Modulator acknowledge: one cycle in sixteen.
    initial forever begin
        @(posedge clk_16M384);
        #1;
        tick++;
        m_tready = (tick % 16 == 0);
    end

    // Monitor: capture acknowledged symbols and count status events.
    initial forever begin
        @(negedge clk_16M384);
        if (m_tready && busy) cap.push_back({m_tvalid, m_tuser, m_tlast, m_tdata});
        if (frame_done) begin
            n_done++;
            if (!prev_last_ack) n_done_bad++;
        end
        if (err_len) n_err++;
        if (s_tvalid && s_tready) n_acc++;
        prev_last_ack = m_tready && m_tlast;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_sym(input logic v, input logic u, input logic l,
                                           input logic [1:0] d);
        return {v, u, l, 6'b0, d};
    endfunction

    function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        repeat (8) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic exp_start(input logic [7:0] len);
        exp_q.delete();
        exp_crc = 8'h00;
        for (int k = 0; k < PRE_LEN; k++) exp_q.push_back(mk_sym(1, 1, 0, (k % 2 == 0) ? 2'd3 : 2'd0));
        for (int k = 7; k >= 0; k--) exp_q.push_back(mk_sym(1, 1, 0, {len[k], len[k]}));
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic fin);
        for (int k = 3; k >= 0; k--) exp_q.push_back(mk_sym(1, 0, fin && !CRC_ON && k == 0, b[2*k+1 -: 2]));
        exp_crc = crc8_ref(exp_crc, b);
    endtask

    task automatic exp_tail();
        if (CRC_ON) begin
            for (int k = 3; k >= 0; k--) exp_q.push_back(mk_sym(1, 0, k == 0, exp_crc[2*k+1 -: 2]));
        end
        for (int g = 0; g < GUARD_LEN; g++) exp_q.push_back(mk_sym(0, 0, 0, 2'd0));
    endtask

    task automatic cmp_syms(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < cap.size()) check($sformatf("%s sym%0d", tag, i), 32'(cap[base+i]), 32'(exp_q[i]));
        end
    endtask

    task automatic cmp_frame(input string tag, input int base);
        check({tag, " count"}, cap.size() - base, exp_q.size());
        cmp_syms(tag, base);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n        = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge clk_16M384);
        while (!s_tready && n < 4000) begin
            @(negedge clk_16M384);
            n++;
        end
        check("byte accepted", s_tready, 1);
        @(posedge clk_16M384);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_acks(input int n);
        repeat (n) begin
            @(negedge clk_16M384);
            while (!m_tready) @(negedge clk_16M384);
        end
        @(posedge clk_16M384);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_16M384);
        while (busy && n < 3000) begin
            @(negedge clk_16M384);
            n++;
        end
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, busy, frame_done, err_len}, 0);
    endtask

    initial begin
        int base, d0, e0, a0, n;

        repeat (3) @(posedge clk_16M384);
        @(negedge clk_16M384);
        check_quiet("reset outputs");
        @(posedge clk_16M384);
        #1;
        rst_16M384 = 1'b0;
        en = 1'b1;

        // Basic frame: one byte 0xB4.
        cfg_len = 8'd0;
        base = cap.size(); d0 = n_done; e0 = n_err;
        exp_start(8'd0); exp_byte(8'hB4, 1); exp_tail();
        send_byte(8'hB4, 1);
        wait_idle("basic");
        cmp_frame("basic", base);
        check("basic frame_done", n_done - d0, 1);
        check("basic err_len", n_err - e0, 0);

        // Underrun: three idle slots between 0xFF and 0x00.
        cfg_len = 8'd1;
        base = cap.size(); d0 = n_done; e0 = n_err;
        exp_start(8'd1); exp_byte(8'hFF, 0);
        repeat (3) exp_q.push_back(mk_sym(0, 0, 0, 2'd0));
        exp_byte(8'h00, 1); exp_tail();
        send_byte(8'hFF, 0);
        wait_acks(14);
        send_byte(8'h00, 1);
        wait_idle("underrun");
        cmp_frame("underrun", base);
        check("underrun err_len", n_err - e0, 0);
        check("underrun frame_done", n_done - d0, 1);

        // Early s_tlast: third byte padded with zeros.
        cfg_len = 8'd2;
        base = cap.size(); e0 = n_err; a0 = n_acc;
        exp_start(8'd2); exp_byte(8'h12, 0); exp_byte(8'h34, 0); exp_byte(8'h00, 1); exp_tail();
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        wait_idle("early");
        cmp_frame("early", base);
        check("early err_len", n_err - e0, 1);
        check("early accepts", n_acc - a0, 2);

        // Reset during payload, then a clean frame.
        cfg_len = 8'd0;
        d0 = n_done;
        send_byte(8'hB4, 1);
        wait_acks(9);
        check("rst busy before", busy, 1);
        rst_16M384 = 1'b1;
        @(posedge clk_16M384);
        @(negedge clk_16M384);
        check_quiet("rst mid-frame outputs");
        @(posedge clk_16M384);
        #1;
        rst_16M384 = 1'b0;
        base = cap.size();
        exp_start(8'd0); exp_byte(8'h5A, 1); exp_tail();
        send_byte(8'h5A, 1);
        wait_idle("restart");
        cmp_frame("restart", base);
        check("restart frame_done", n_done - d0, 1);

        // Back-to-back frames: guard slots, then next preamble starts with 3.
        base = cap.size(); d0 = n_done;
        exp_start(8'd0); exp_byte(8'hC3, 1); exp_tail();
        exp_q.push_back(mk_sym(1, 1, 0, 2'd3));
        s_tdata = 8'hC3; s_tlast = 1'b1; s_tvalid = 1'b1;
        n = 0;
        while (cap.size() < base + exp_q.size() && n < 4000) begin
            @(negedge clk_16M384);
            n++;
        end
        check("b2b captured", cap.size() >= base + exp_q.size(), 1);
        cmp_syms("b2b", base);
        @(posedge clk_16M384);
        #1;
        en = 1'b0;
        wait_idle("b2b");
        check("b2b frame_done", n_done - d0, 2);
        repeat (40) @(negedge clk_16M384);
        check("en low no start", busy, 0);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        en = 1'b1;

`ifdef PSK_SCHED_CRC_EN
        // CRC of 0x01 is 0x07: payload 0,0,0,1 then CRC 0,0,1,3.
        cfg_len = 8'd0;
        base = cap.size();
        exp_start(8'd0);
        exp_q.push_back(mk_sym(1, 0, 0, 2'd0));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd0));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd0));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd1));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd0));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd0));
        exp_q.push_back(mk_sym(1, 0, 0, 2'd1));
        exp_q.push_back(mk_sym(1, 0, 1, 2'd3));
        for (int g = 0; g < GUARD_LEN; g++) exp_q.push_back(mk_sym(0, 0, 0, 2'd0));
        send_byte(8'h01, 1);
        wait_idle("crc");
        cmp_frame("crc", base);
`endif

        check("frame_done timing", n_done_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
